// File: rtl/multiword_addsub_ctrl.sv
// multiword_addsub_ctrl
// Adds or subtracts two N-bit operands (N = SLICE_W*WORDS) by running them
// through one SLICE_W-bit add/sub slice for WORDS cycles. The least significant
// word goes first, and the carry/borrow is registered between slices.
// Optional feature: define OVERFLOW_DETECT_EN to drive ovf with the signed
// overflow of the final slice. When it is not defined, ovf is tied to 0.
//
// Handshake: start is sampled on a rising edge only while busy=0, which covers
// both IDLE and the DONE cycle, so requests can run back to back. a, b and sub
// are captured on that same edge. done is a one-cycle pulse that arrives WORDS
// cycles after the accept edge. result, cout and ovf are then held until the
// next accepted operation begins to overwrite them.
module multiword_addsub_ctrl #(
  parameter int SLICE_W = 16,
  parameter int WORDS   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sub,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*WORDS-1:0]   result,
  output logic                       cout,
  output logic                       ovf,
  output logic [1:0]                 dbg_state
);

  localparam int N  = SLICE_W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic            sub_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            accept;
  logic            last_slice;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   sum;

  assign dbg_state = state_q;

  // Next-state logic and request acceptance
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last_slice = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One slice of the ripple add/sub; for subtraction B is inverted and carry starts at 1
  always_comb begin
    a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
    b_sl = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
    sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, slice sequencing, result accumulation and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last_slice;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        carry_q <= sub;
        idx_q   <= '0;
        busy    <= 1'b1;
      end else if (state_q == RUN) begin
        result[idx_q*SLICE_W +: SLICE_W] <= sum[SLICE_W-1:0];
        carry_q <= sum[SLICE_W];
        idx_q   <= idx_q + 1'b1;
        if (last_slice) begin
          cout <= sum[SLICE_W];
          busy <= 1'b0;
        end
      end
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic [SLICE_W-1:0] low_sum;

  // Carry into the MSB of the slice, taken from the lower SLICE_W-1 bits
  always_comb begin
    low_sum = {1'b0, a_sl[SLICE_W-2:0]} + {1'b0, b_sl[SLICE_W-2:0]}
            + {{(SLICE_W-1){1'b0}}, carry_q};
  end

  // Signed overflow of the most significant slice, captured along with cout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ovf <= 1'b0;
    else if (last_slice) ovf <= low_sum[SLICE_W-1] ^ sum[SLICE_W];
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
